// File: rtl/seq_bit_serializer_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the bit serializer that feeds the serial sequence
// detector: FSM state encodings and the default idle level of the serial line.
//
// Contents
//   state_t           S_IDLE / S_SHIFT / S_PAR serializer states
//   IDLE_BIT_DEFAULT  level driven on x while no bit is valid
// ----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2   // entered only when SEQ_SER_PARITY_EN is defined
    } state_t;

    localparam logic IDLE_BIT_DEFAULT = 1'b1;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// ----------------------------------------------------------------------------
// seq_bit_serializer_if
// Bundles the parallel-word handshake and the serial output of the
// serializer.
//
// Signals
//   din        [WIDTH-1:0] parallel word, din[WIDTH-1] goes out first
//   din_valid  din holds a word
//   din_ready  serializer can take a word this cycle
//   x          serial bit
//   x_valid    x carries a data or parity bit
//   busy       serializer is not idle
//   done       last bit of a word is on x
// Modports
//   master  word source / serial consumer side
//   slave   serializer side
// ----------------------------------------------------------------------------
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;

    modport master (
        output din, din_valid,
        input  din_ready, x, x_valid, busy, done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, x, x_valid, busy, done
    );
endinterface

// File: rtl/seq_bit_serializer_ser_bit_counter.sv
// ----------------------------------------------------------------------------
// ser_bit_counter
// Counts the data bits of a word still to be sent after the one on x.
// Loads WIDTH-1, decrements towards zero and saturates there.
//
// Ports
//   clk    clock, rising edge
//   reset  synchronous active-high reset, clears the count
//   load   load WIDTH-1 (word accepted)
//   dec    count one bit sent
//   last   count is zero: the last data bit is on x
// ----------------------------------------------------------------------------
module ser_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic last
);
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LOAD_VAL = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is written with non-blocking (<=) so every
    // register samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/seq_bit_serializer.sv
// ----------------------------------------------------------------------------
// seq_bit_serializer
// Accepts parallel words over a valid/ready handshake and shifts them out
// MSB-first, one bit per clock, on x. Back-to-back words stream without a
// gap; with no data x holds IDLE_BIT and x_valid is low.
//
// Configuration
//   SEQ_SER_PARITY_EN  when defined, every word is followed by one even-parity
//                      bit (word period WIDTH+1); otherwise period is WIDTH.
// Parameters
//   WIDTH     data word width, WIDTH >= 2
//   IDLE_BIT  level on x while no bit is valid
// Ports
//   clk    clock, rising edge
//   reset  synchronous active-high reset (priority over an accept)
//   bus    seq_bit_serializer_if.slave: din/din_valid/din_ready handshake,
//          registered x/x_valid, busy, done
// ----------------------------------------------------------------------------
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_bit_serializer_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             cnt_load, cnt_dec, cnt_last;
    logic             din_ready, done, accept;
`ifdef SEQ_SER_PARITY_EN
    logic             par_q, par_d;
`endif

    ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .last  (cnt_last)
    );

    // NOTE: every variable driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        x_d       = x_q;
        x_valid_d = x_valid_q;
`ifdef SEQ_SER_PARITY_EN
        par_d     = par_q;
`endif
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        din_ready = 1'b0;
        done      = 1'b0;

        // Ready/done depend only on state and count; the next word is taken
        // while the final bit of the current one is still on x.
        unique case (state_q)
            S_IDLE:  din_ready = 1'b1;
            S_SHIFT: begin
`ifndef SEQ_SER_PARITY_EN
                if (cnt_last) begin
                    din_ready = 1'b1;
                    done      = 1'b1;
                end
`endif
            end
`ifdef SEQ_SER_PARITY_EN
            S_PAR: begin
                din_ready = 1'b1;
                done      = 1'b1;
            end
`endif
            default: ;
        endcase

        if (reset) begin
            din_ready = 1'b0;
        end
        accept = bus.din_valid && din_ready;

        if (accept) begin
            // MSB goes straight to x; the shift register holds the rest.
            x_d       = bus.din[WIDTH-1];
            x_valid_d = 1'b1;
            sh_d      = {bus.din[WIDTH-2:0], 1'b0};
`ifdef SEQ_SER_PARITY_EN
            par_d     = ^bus.din;
`endif
            cnt_load  = 1'b1;
            state_d   = S_SHIFT;
        end else begin
            unique case (state_q)
                S_SHIFT: begin
                    if (!cnt_last) begin
                        x_d     = sh_q[WIDTH-1];
                        sh_d    = {sh_q[WIDTH-2:0], 1'b0};
                        cnt_dec = 1'b1;
                    end else begin
`ifdef SEQ_SER_PARITY_EN
                        x_d     = par_q;
                        state_d = S_PAR;
`else
                        x_d       = IDLE_BIT;
                        x_valid_d = 1'b0;
                        state_d   = S_IDLE;
`endif
                    end
                end
                S_PAR: begin
                    x_d       = IDLE_BIT;
                    x_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
            // NOTE: the shift register is cleared on reset as well, so a word
            // dropped mid-flight leaves no stale bits behind.
            sh_q      <= '0;
`ifdef SEQ_SER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            sh_q      <= sh_d;
`ifdef SEQ_SER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign bus.din_ready = din_ready;
    assign bus.x         = x_q;
    assign bus.x_valid   = x_valid_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// ----------------------------------------------------------------------------
// tb_seq_bit_serializer
// Drives two serializers (WIDTH=8 with IDLE_BIT=1, WIDTH=2 with IDLE_BIT=0)
// and compares every cycle against a bit-queue reference model: an accepted
// word becomes its list of bits (plus parity when enabled), one bit leaves
// the list per clock, and ready/done/busy follow from how many remain.
// ----------------------------------------------------------------------------
module tb_seq_bit_serializer;
    import seq_pkg::*;

    localparam int W  = 8;
    localparam int W2 = 2;
`ifdef SEQ_SER_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int P  = W + PAR_EN;
    localparam int P2 = W2 + PAR_EN;

    logic clk = 1'b0;
    logic reset, reset2;
    always #5 clk = ~clk;

    seq_bit_serializer_if #(.WIDTH(W))  bus ();
    seq_bit_serializer_if #(.WIDTH(W2)) bus2 ();

    seq_bit_serializer #(.WIDTH(W), .IDLE_BIT(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    seq_bit_serializer #(.WIDTH(W2), .IDLE_BIT(1'b0)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: remaining bits per DUT, front = bit on x.
    bit q0[$];
    bit q1[$];
    bit         p_rst[2];
    bit         p_v[2];
    logic [7:0] p_w[2];

    function automatic int qsize(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    function automatic bit model_ready(input int id);
        return !p_rst[id] && (qsize(id) <= 1);
    endfunction

    // {x, x_valid, done, busy, din_ready}
    function automatic logic [4:0] exp_out(input int id);
        logic idle_lvl;
        logic front;
        idle_lvl = (id == 0) ? 1'b1 : 1'b0;
        if (qsize(id) == 0) return {idle_lvl, 1'b0, 1'b0, 1'b0, model_ready(id)};
        front = (id == 0) ? q0[0] : q1[0];
        return {front, 1'b1, (qsize(id) == 1), 1'b1, model_ready(id)};
    endfunction

    function automatic logic [4:0] obs_out(input int id);
        if (id == 0) return {bus.x, bus.x_valid, bus.done, bus.busy, bus.din_ready};
        return {bus2.x, bus2.x_valid, bus2.done, bus2.busy, bus2.din_ready};
    endfunction

    task automatic model_edge(input int id);
        int width;
        bit acc;
        bit p;
        bit bits[$];
        width = (id == 0) ? W : W2;
        acc   = p_v[id] && model_ready(id);
        p     = 1'b0;
        if (acc) begin
            for (int i = width - 1; i >= 0; i--) begin
                bits.push_back(p_w[id][i]);
                p ^= p_w[id][i];
            end
            if (PAR_EN != 0) bits.push_back(p);
        end
        if (id == 0) begin
            if (p_rst[0]) q0.delete();
            else if (acc) q0 = bits;
            else if (q0.size() > 0) void'(q0.pop_front());
        end else begin
            if (p_rst[1]) q1.delete();
            else if (acc) q1 = bits;
            else if (q1.size() > 0) void'(q1.pop_front());
        end
    endtask

    task automatic drive(input int id, input bit r, input bit v, input logic [7:0] w);
        p_rst[id] = r;
        p_v[id]   = v;
        p_w[id]   = w;
        if (id == 0) begin
            reset         = r;
            bus.din_valid = v;
            bus.din       = w;
        end else begin
            reset2         = r;
            bus2.din_valid = v;
            bus2.din       = w[W2-1:0];
        end
    endtask

    task automatic tick(input int id);
        @(posedge clk);
        #1;
        model_edge(id);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [4:0] o;
        for (int c = 0; c < 2; c++) begin
            drive(0, 1'b1, 1'b1, 8'h5A);
            drive(1, 1'b1, 1'b1, 8'h01);
            #1;
            o = obs_out(0);
            checks++;
            if (o !== 5'b10000) begin
                errors++;
                $display("FAIL reset_w8 cyc %0d got %b want %b", c, o, 5'b10000);
            end
            o = obs_out(1);
            checks++;
            if (o !== 5'b00000) begin
                errors++;
                $display("FAIL reset_w2 cyc %0d got %b want %b", c, o, 5'b00000);
            end
            @(posedge clk);
            #1;
            model_edge(0);
            model_edge(1);
        end
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        #1;
        o = obs_out(0);
        checks++;
        if (o !== 5'b10001) begin
            errors++;
            $display("FAIL reset_release_w8 got %b want %b", o, 5'b10001);
        end
        o = obs_out(1);
        checks++;
        if (o !== 5'b00001) begin
            errors++;
            $display("FAIL reset_release_w2 got %b want %b", o, 5'b00001);
        end
        tick(0);
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_word();
        logic [4:0] o, e;
        logic [7:0] got;
        int nvalid, done_at;
        got = '0; nvalid = 0; done_at = -1;
        drive(0, 1'b0, 1'b1, 8'h36);
        #1;
        e = exp_out(0); o = obs_out(0);
        checks++;
        if (o !== e) begin errors++; $display("FAIL single_accept got %b want %b", o, e); end
        tick(0);
        for (int c = 0; c < P + 2; c++) begin
            drive(0, 1'b0, 1'b0, 8'h00);
            #1;
            e = exp_out(0); o = obs_out(0);
            checks++;
            if (o !== e) begin errors++; $display("FAIL single_word cyc %0d got %b want %b", c, o, e); end
            if (bus.x_valid === 1'b1) begin
                if (nvalid < W) got = {got[6:0], bus.x};
                nvalid++;
            end
            if (bus.done === 1'b1) done_at = c;
            tick(0);
        end
        checks++;
        if (got !== 8'h36) begin errors++; $display("FAIL single_bits got %h want %h", got, 8'h36); end
        checks++;
        if (nvalid != P) begin errors++; $display("FAIL single_len got %0d want %0d", nvalid, P); end
        checks++;
        if (done_at != P - 1) begin errors++; $display("FAIL single_done got %0d want %0d", done_at, P - 1); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [4:0]  o, e;
        logic [7:0]  words [2];
        logic [15:0] got;
        int idx, nvalid, hs, gaps;
        bit seen_valid, ended;
        words[0] = 8'hA5; words[1] = 8'h3C;
        idx = 0; nvalid = 0; hs = 0; gaps = 0; got = '0; seen_valid = 0; ended = 0;
        for (int c = 0; c < 2 * P + 3; c++) begin
            if (idx < 2) drive(0, 1'b0, 1'b1, words[idx]);
            else         drive(0, 1'b0, 1'b0, 8'h00);
            #1;
            e = exp_out(0); o = obs_out(0);
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b cyc %0d got %b want %b", c, o, e); end
            if (bus.din_valid === 1'b1 && bus.din_ready === 1'b1) hs++;
            if (bus.x_valid === 1'b1) begin
                if (ended) gaps++;
                if ((nvalid % P) < W) got = {got[14:0], bus.x};
                nvalid++;
                seen_valid = 1;
            end else if (seen_valid) begin
                ended = 1;
            end
            if (p_v[0] && model_ready(0)) idx++;
            tick(0);
        end
        checks++;
        if (got !== 16'hA53C) begin errors++; $display("FAIL b2b_bits got %h want %h", got, 16'hA53C); end
        checks++;
        if (nvalid != 2 * P || gaps != 0) begin
            errors++;
            $display("FAIL b2b_stream valid %0d gaps %0d want %0d and 0", nvalid, gaps, 2 * P);
        end
        checks++;
        if (hs != 2) begin errors++; $display("FAIL b2b_handshakes got %0d want 2", hs); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_word();
        logic [4:0] o, e;
        int leaked;
        leaked = 0;
        drive(0, 1'b0, 1'b1, 8'hFF);
        #1;
        tick(0);
        for (int c = 1; c <= 4; c++) begin
            // Reset goes high while the 4th bit is on x.
            drive(0, (c == 4), 1'b0, 8'h00);
            #1;
            e = exp_out(0); o = obs_out(0);
            checks++;
            if (o !== e) begin errors++; $display("FAIL rst_mid bit %0d got %b want %b", c, o, e); end
            tick(0);
        end
        drive(0, 1'b1, 1'b1, 8'h81);
        #1;
        o = obs_out(0);
        checks++;
        if (o !== 5'b10000) begin errors++; $display("FAIL rst_mid_held got %b want %b", o, 5'b10000); end
        tick(0);
        for (int c = 0; c < 10; c++) begin
            drive(0, 1'b0, 1'b0, 8'h00);
            #1;
            e = exp_out(0); o = obs_out(0);
            checks++;
            if (o !== e) begin errors++; $display("FAIL rst_mid_after cyc %0d got %b want %b", c, o, e); end
            if (bus.x_valid !== 1'b0) leaked++;
            tick(0);
        end
        checks++;
        if (leaked != 0) begin errors++; $display("FAIL rst_mid_leak got %0d bits want 0", leaked); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_valid_toggle();
        logic [4:0] o, e;
        bit v;
        logic [7:0] w;
        v = 0; w = '0;
        for (int c = 0; c < 300; c++) begin
            if (!v) begin
                v = ($urandom_range(0, 2) != 0);
                w = 8'($urandom());
            end else if ($urandom_range(0, 7) == 0) begin
                v = 0;
            end
            drive(0, 1'b0, v, w);
            #1;
            e = exp_out(0); o = obs_out(0);
            checks++;
            if (o !== e) begin errors++; $display("FAIL toggle cyc %0d din %h got %b want %b", c, w, o, e); end
            if (v && model_ready(0)) v = 0;
            tick(0);
        end
        for (int c = 0; c < P + 2; c++) begin
            drive(0, 1'b0, 1'b0, 8'h00);
            #1;
            e = exp_out(0); o = obs_out(0);
            checks++;
            if (o !== e) begin errors++; $display("FAIL toggle_drain cyc %0d got %b want %b", c, o, e); end
            tick(0);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_width2();
        logic [4:0] o, e;
        int ndone, pat_err;
        bit v;
        logic [7:0] w;
        ndone = 0; pat_err = 0;
        drive(1, 1'b0, 1'b1, 8'h01);
        #1;
        tick(1);
        for (int k = 0; k < 12; k++) begin
            drive(1, 1'b0, 1'b1, 8'h01);
            #1;
            e = exp_out(1); o = obs_out(1);
            checks++;
            if (o !== e) begin errors++; $display("FAIL w2_cont cyc %0d got %b want %b", k, o, e); end
            // Word 2'b01 streams as 0,1 (then parity 1 when enabled).
            if (bus2.x !== (((k % P2) == 0) ? 1'b0 : 1'b1) || bus2.x_valid !== 1'b1) pat_err++;
            if (bus2.done === 1'b1) ndone++;
            tick(1);
        end
        checks++;
        if (pat_err != 0) begin errors++; $display("FAIL w2_pattern bad cycles got %0d want 0", pat_err); end
        checks++;
        if (ndone != 12 / P2) begin errors++; $display("FAIL w2_done got %0d want %0d", ndone, 12 / P2); end
        v = 1; w = 8'h01;
        for (int c = 0; c < 80; c++) begin
            if (c >= 74) v = 0;
            else if (!v) begin
                v = ($urandom_range(0, 1) != 0);
                w = 8'($urandom_range(0, 3));
            end
            drive(1, 1'b0, v, w);
            #1;
            e = exp_out(1); o = obs_out(1);
            checks++;
            if (o !== e) begin errors++; $display("FAIL w2_rand cyc %0d din %0d got %b want %b", c, w[1:0], o, e); end
            if (v && model_ready(1)) v = 0;
            tick(1);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1; reset2 = 1'b1;
        bus.din = '0; bus.din_valid = 1'b0;
        bus2.din = '0; bus2.din_valid = 1'b0;
        p_rst[0] = 1; p_rst[1] = 1; p_v[0] = 0; p_v[1] = 0; p_w[0] = '0; p_w[1] = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_reset_mid_word();
        test_valid_toggle();
        test_width2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
